// File: rtl/cnn16_conv3x3_engine.sv
// 3x3 valid-convolution engine: RAM master that loads 9 Q8.8 weights, MACs each
// window through a 36-bit accumulator and writes saturated results back in raster order.
module cnn16_conv3x3_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int FRAC_BITS  = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  relu_en,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] ker_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done
);

  localparam int ACC_W  = 36;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (DATA_WIDTH - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_K, S_CONV_RD, S_CONV_LAST, S_CONV_WR, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [3:0]                   r_cnt;
  logic [1:0]                   r_kr, r_kc;
  logic [ADDR_WIDTH-1:0]        r_row, r_col;
  logic [ADDR_WIDTH-1:0]        r_src, r_ker, r_dst;
  logic                         r_relu;
  logic signed [DATA_WIDTH-1:0] r_w [0:8];
  logic signed [ACC_W-1:0]      r_acc;
  logic                         r_mem_write;
  logic [ADDR_WIDTH-1:0]        r_mem_addr;
  logic [DATA_WIDTH-1:0]        r_mem_wdata;
  logic                         r_busy, r_done;

  logic signed [DATA_WIDTH-1:0] w_coef;
  logic signed [PROD_W-1:0]     w_pix_x, w_coef_x, w_prod;
  logic signed [ACC_W-1:0]      w_prod_ext, w_acc_next;
  logic [1:0]                   w_nkr, w_nkc;
  logic                         w_last_col, w_last_row;
  logic [ADDR_WIDTH-1:0]        w_ncol, w_nrow;

  // Floor shift back to Q8.8, clamp to the 16-bit range, optional ReLU.
  function automatic logic [DATA_WIDTH-1:0] sat_result(input logic signed [ACC_W-1:0] acc,
                                                       input logic relu);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC_BITS;
    if (relu && sh < 0) return '0;
    if (sh > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
    if (sh < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    return sh[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [ADDR_WIDTH-1:0] row,
                                                     input logic [ADDR_WIDTH-1:0] col,
                                                     input logic [1:0] kr,
                                                     input logic [1:0] kc);
    logic [ADDR_WIDTH-1:0] rr;
    rr = row + ADDR_WIDTH'(kr);
    return base + rr * ADDR_WIDTH'(IMG_W) + col + ADDR_WIDTH'(kc);
  endfunction

  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign done      = r_done;

  // Weight paired with the pixel arriving this cycle (issued one cycle earlier).
  always_comb begin
    w_coef = '0;
    if (r_state == S_CONV_LAST)
      w_coef = r_w[8];
    else if (r_state == S_CONV_RD && r_cnt != 4'd0)
      w_coef = r_w[r_cnt - 4'd1];
  end

  assign w_pix_x    = {{DATA_WIDTH{mem_rdata[DATA_WIDTH-1]}}, mem_rdata};
  assign w_coef_x   = {{DATA_WIDTH{w_coef[DATA_WIDTH-1]}}, w_coef};
  assign w_prod     = w_pix_x * w_coef_x;
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_acc_next = r_acc + w_prod_ext;

  assign w_nkc      = (r_kc == 2'd2) ? 2'd0 : r_kc + 2'd1;
  assign w_nkr      = (r_kc == 2'd2) ? r_kr + 2'd1 : r_kr;
  assign w_last_col = (r_col == ADDR_WIDTH'(IMG_W - 3));
  assign w_last_row = (r_row == ADDR_WIDTH'(IMG_H - 3));
  assign w_ncol     = w_last_col ? '0 : r_col + ADDR_WIDTH'(1);
  assign w_nrow     = w_last_col ? r_row + ADDR_WIDTH'(1) : r_row;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_next = S_LOAD_K;
      S_LOAD_K:    if (r_cnt == 4'd9) w_next = S_CONV_RD;
      S_CONV_RD:   if (r_cnt == 4'd8) w_next = S_CONV_LAST;
      S_CONV_LAST: w_next = S_CONV_WR;
      S_CONV_WR:   w_next = (w_last_col && w_last_row) ? S_DONE : S_CONV_RD;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_kr        <= '0;
      r_kc        <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_src       <= '0;
      r_ker       <= '0;
      r_dst       <= '0;
      r_relu      <= 1'b0;
      r_acc       <= '0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < 9; i++) r_w[i] <= '0;
    end else begin
      r_state     <= w_next;
      r_mem_write <= 1'b0;
      r_busy      <= (w_next != S_IDLE) && (w_next != S_DONE);
      r_done      <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src      <= src_base;
            r_ker      <= ker_base;
            r_dst      <= dst_base;
            r_relu     <= relu_en;
            r_cnt      <= '0;
            r_mem_addr <= ker_base;
          end
        end
        S_LOAD_K: begin
          if (r_cnt != 4'd0) r_w[r_cnt - 4'd1] <= mem_rdata;
          if (r_cnt == 4'd9) begin
            r_cnt      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_kr       <= '0;
            r_kc       <= '0;
            r_mem_addr <= r_src;
          end else begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt < 4'd8) r_mem_addr <= r_ker + ADDR_WIDTH'(r_cnt + 4'd1);
          end
        end
        S_CONV_RD: begin
          // Tap-0 cycle sees stale read data, so it clears instead of accumulating.
          r_acc <= (r_cnt == 4'd0) ? '0 : w_acc_next;
          if (r_cnt == 4'd8) begin
            r_cnt <= '0;
          end else begin
            r_cnt      <= r_cnt + 4'd1;
            r_kr       <= w_nkr;
            r_kc       <= w_nkc;
            r_mem_addr <= pix_addr(r_src, r_row, r_col, w_nkr, w_nkc);
          end
        end
        S_CONV_LAST: begin
          r_acc       <= w_acc_next;
          r_mem_write <= 1'b1;
          r_mem_addr  <= r_dst + r_row * ADDR_WIDTH'(IMG_W - 2) + r_col;
          r_mem_wdata <= sat_result(w_acc_next, r_relu);
        end
        S_CONV_WR: begin
          r_col <= w_ncol;
          r_row <= w_nrow;
          r_kr  <= '0;
          r_kc  <= '0;
          if (!(w_last_col && w_last_row))
            r_mem_addr <= pix_addr(r_src, w_nrow, w_ncol, 2'd0, 2'd0);
        end
        default: ;
      endcase
    end
  end

endmodule
